// File: rtl/bus_arbiter_if.sv
// Signal bundle for the two-master data-bus arbiter: both master request/response
// channels plus the shared slave-side bus.
interface bus_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              m0_req;
   logic [ADDR_W-1:0] m0_addr;
   logic [DATA_W-1:0] m0_wdata;
   logic              m0_we;
   logic              m0_ack;
   logic              m0_err;
   logic [DATA_W-1:0] m0_rdata;

   logic              m1_req;
   logic [ADDR_W-1:0] m1_addr;
   logic [DATA_W-1:0] m1_wdata;
   logic              m1_we;
   logic              m1_ack;
   logic              m1_err;
   logic [DATA_W-1:0] m1_rdata;

   logic              s_valid;
   logic [ADDR_W-1:0] s_addr;
   logic [DATA_W-1:0] s_wdata;
   logic              s_we;
   logic [DATA_W-1:0] s_rdata;
   logic              s_ready;
   logic              gnt_id;

   // Arbiter view: receives master requests and slave responses.
   modport slave (
      input  m0_req, m0_addr, m0_wdata, m0_we,
      output m0_ack, m0_err, m0_rdata,
      input  m1_req, m1_addr, m1_wdata, m1_we,
      output m1_ack, m1_err, m1_rdata,
      output s_valid, s_addr, s_wdata, s_we, gnt_id,
      input  s_rdata, s_ready
   );

   // Environment view: drives requests and slave responses.
   modport master (
      output m0_req, m0_addr, m0_wdata, m0_we,
      input  m0_ack, m0_err, m0_rdata,
      output m1_req, m1_addr, m1_wdata, m1_we,
      input  m1_ack, m1_err, m1_rdata,
      input  s_valid, s_addr, s_wdata, s_we, gnt_id,
      output s_rdata, s_ready
   );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin two-master arbiter in front of a single slave bus, with a
// watchdog that terminates transactions the slave never completes.
module bus_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 16
) (
   input logic          clk,
   input logic          rst,
   bus_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   localparam bit             TO_EN    = (TIMEOUT != 0);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT != 0) ? TIMEOUT - 1 : 0);

   state_t            state_reg;
   logic              last_gnt_reg;
   logic              gnt_reg;
   logic              s_valid_reg;
   logic              s_we_reg;
   logic [ADDR_W-1:0] s_addr_reg;
   logic [DATA_W-1:0] s_wdata_reg;
   logic [CNT_W-1:0]  cnt_reg;
   logic [1:0]        ack_reg;
   logic [1:0]        err_reg;
   logic [DATA_W-1:0] rdata_reg [2];

   logic any_req;
   logic win;

   // Contention goes to the master that did not win last time.
   always_comb begin
      any_req = bus.m0_req | bus.m1_req;
      win     = (bus.m0_req & bus.m1_req) ? ~last_gnt_reg : bus.m1_req;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg    <= IDLE;
         last_gnt_reg <= 1'b1;
         gnt_reg      <= 1'b0;
         s_valid_reg  <= 1'b0;
         s_we_reg     <= 1'b0;
         s_addr_reg   <= '0;
         s_wdata_reg  <= '0;
         cnt_reg      <= '0;
         ack_reg      <= '0;
         err_reg      <= '0;
         rdata_reg[0] <= '0;
         rdata_reg[1] <= '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (any_req) begin
                  s_addr_reg   <= win ? bus.m1_addr  : bus.m0_addr;
                  s_wdata_reg  <= win ? bus.m1_wdata : bus.m0_wdata;
                  s_we_reg     <= win ? bus.m1_we    : bus.m0_we;
                  s_valid_reg  <= 1'b1;
                  gnt_reg      <= win;
                  last_gnt_reg <= win;
                  cnt_reg      <= '0;
                  state_reg    <= BUSY;
               end
            end
            BUSY: begin
               // s_ready takes priority over an expiring watchdog on the same edge.
               if (bus.s_ready) begin
                  s_valid_reg        <= 1'b0;
                  ack_reg[gnt_reg]   <= 1'b1;
                  err_reg[gnt_reg]   <= 1'b0;
                  rdata_reg[gnt_reg] <= s_we_reg ? '0 : bus.s_rdata;
                  state_reg          <= RESP;
               end else if (TO_EN && (cnt_reg == CNT_LAST)) begin
                  s_valid_reg        <= 1'b0;
                  ack_reg[gnt_reg]   <= 1'b1;
                  err_reg[gnt_reg]   <= 1'b1;
                  rdata_reg[gnt_reg] <= '0;
                  state_reg          <= RESP;
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end
            RESP: begin
               ack_reg      <= '0;
               err_reg      <= '0;
               rdata_reg[0] <= '0;
               rdata_reg[1] <= '0;
               state_reg    <= IDLE;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.s_valid  = s_valid_reg;
   assign bus.s_addr   = s_addr_reg;
   assign bus.s_wdata  = s_wdata_reg;
   assign bus.s_we     = s_we_reg;
   assign bus.gnt_id   = gnt_reg;
   assign bus.m0_ack   = ack_reg[0];
   assign bus.m0_err   = err_reg[0];
   assign bus.m0_rdata = rdata_reg[0];
   assign bus.m1_ack   = ack_reg[1];
   assign bus.m1_err   = err_reg[1];
   assign bus.m1_rdata = rdata_reg[1];
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: inputs change and outputs are checked on the
// falling edge, one line per transaction.
module tb_bus_arbiter;
   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 32;
   localparam int TIMEOUT = 16;
   localparam int CNT_W   = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   bus_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   bus_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      bus.m0_req = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0; bus.m0_we = 1'b0;
      bus.m1_req = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0; bus.m1_we = 1'b0;
      bus.s_ready = 1'b0; bus.s_rdata = '0;
   endtask

   initial begin
      logic exp_gnt;
      idle_inputs();

      // Reset state
      step();
      chk("rst_s_valid", 64'(bus.s_valid), 64'd0);
      chk("rst_acks", 64'({bus.m0_ack, bus.m1_ack}), 64'd0);
      chk("rst_gnt_id", 64'(bus.gnt_id), 64'd0);
      rst = 1'b1;
      step();
      $display("reset released");

      // 1: single read by m0, ready on 2nd BUSY cycle
      bus.m0_req = 1'b1; bus.m0_addr = 32'h100; bus.m0_we = 1'b0;
      step();
      chk("t1_s_valid", 64'(bus.s_valid), 64'd1);
      chk("t1_s_addr", 64'(bus.s_addr), 64'h100);
      chk("t1_s_we", 64'(bus.s_we), 64'd0);
      chk("t1_gnt", 64'(bus.gnt_id), 64'd0);
      step();
      chk("t1_busy2_valid", 64'(bus.s_valid), 64'd1);
      chk("t1_busy2_noack", 64'(bus.m0_ack), 64'd0);
      bus.s_ready = 1'b1; bus.s_rdata = 32'hDEADBEEF;
      step();
      chk("t1_ack", 64'(bus.m0_ack), 64'd1);
      chk("t1_rdata", 64'(bus.m0_rdata), 64'hDEADBEEF);
      chk("t1_err", 64'(bus.m0_err), 64'd0);
      chk("t1_m1_ack", 64'(bus.m1_ack), 64'd0);
      chk("t1_valid_drop", 64'(bus.s_valid), 64'd0);
      bus.m0_req = 1'b0; bus.s_ready = 1'b0;
      step();
      chk("t1_ack_clear", 64'(bus.m0_ack), 64'd0);
      chk("t1_rdata_clear", 64'(bus.m0_rdata), 64'd0);
      $display("txn read m0 addr=0x100 rdata=0x%0h", 32'hDEADBEEF);

      // 2: contention right after reset alternates 0,1,0,1
      rst = 1'b0;
      #1;
      rst = 1'b1;
      bus.m0_req = 1'b1; bus.m0_addr = 32'h200;
      bus.m1_req = 1'b1; bus.m1_addr = 32'h300;
      for (int i = 0; i < 4; i++) begin
         exp_gnt = i[0];
         step();
         chk("t2_gnt", 64'(bus.gnt_id), 64'(exp_gnt));
         chk("t2_addr", 64'(bus.s_addr), exp_gnt ? 64'h300 : 64'h200);
         bus.s_ready = 1'b1; bus.s_rdata = 32'h1000 + i;
         step();
         chk("t2_ack_win", 64'(exp_gnt ? bus.m1_ack : bus.m0_ack), 64'd1);
         chk("t2_ack_other", 64'(exp_gnt ? bus.m0_ack : bus.m1_ack), 64'd0);
         bus.s_ready = 1'b0;
         step();
         chk("t2_idle_valid", 64'(bus.s_valid), 64'd0);
         $display("txn contention %0d gnt_id=%0d", i, exp_gnt);
      end
      bus.m0_req = 1'b0;

      // 3: m1 write to GPIO, ready immediately (also high while still IDLE)
      bus.m1_addr = 32'h1388; bus.m1_wdata = 32'hA5; bus.m1_we = 1'b1;
      bus.s_ready = 1'b1; bus.s_rdata = 32'h12345678;
      step();
      chk("t3_valid", 64'(bus.s_valid), 64'd1);
      chk("t3_addr", 64'(bus.s_addr), 64'h1388);
      chk("t3_wdata", 64'(bus.s_wdata), 64'hA5);
      chk("t3_we", 64'(bus.s_we), 64'd1);
      chk("t3_gnt", 64'(bus.gnt_id), 64'd1);
      step();
      chk("t3_valid_one_cycle", 64'(bus.s_valid), 64'd0);
      chk("t3_m1_ack", 64'(bus.m1_ack), 64'd1);
      chk("t3_m1_rdata", 64'(bus.m1_rdata), 64'd0);
      chk("t3_m0_ack", 64'(bus.m0_ack), 64'd0);
      bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.s_ready = 1'b0;
      step();
      $display("txn write m1 addr=0x1388 wdata=0xa5");

      // 4a: timeout with s_ready held low
      bus.m0_req = 1'b1; bus.m0_addr = 32'h400; bus.m0_we = 1'b0;
      bus.s_rdata = 32'h55AA55AA;
      step();
      for (int i = 0; i < TIMEOUT; i++) begin
         chk("t4_valid_hold", 64'(bus.s_valid), 64'd1);
         step();
      end
      chk("t4_valid_drop", 64'(bus.s_valid), 64'd0);
      chk("t4_ack", 64'(bus.m0_ack), 64'd1);
      chk("t4_err", 64'(bus.m0_err), 64'd1);
      chk("t4_rdata", 64'(bus.m0_rdata), 64'd0);
      bus.m0_req = 1'b0;
      step();
      chk("t4_err_clear", 64'(bus.m0_err), 64'd0);
      $display("txn timeout m0 addr=0x400");

      // 4b: s_ready on the 16th BUSY cycle beats the watchdog
      bus.m0_req = 1'b1;
      step();
      for (int i = 0; i < TIMEOUT - 1; i++) begin
         chk("t4b_valid_hold", 64'(bus.s_valid), 64'd1);
         step();
      end
      bus.s_ready = 1'b1; bus.s_rdata = 32'hCAFE0001;
      step();
      chk("t4b_ack", 64'(bus.m0_ack), 64'd1);
      chk("t4b_err", 64'(bus.m0_err), 64'd0);
      chk("t4b_rdata", 64'(bus.m0_rdata), 64'hCAFE0001);
      bus.m0_req = 1'b0; bus.s_ready = 1'b0;
      step();
      $display("txn late-ready m0 rdata=0x%0h", 32'hCAFE0001);

      // 5: asynchronous reset during BUSY, then m0 wins the next contention
      bus.m1_req = 1'b1; bus.m1_addr = 32'h500;
      step();
      chk("t5_busy_valid", 64'(bus.s_valid), 64'd1);
      chk("t5_busy_gnt", 64'(bus.gnt_id), 64'd1);
      #2;
      rst = 1'b0;
      #1;
      chk("t5_async_valid", 64'(bus.s_valid), 64'd0);
      chk("t5_async_gnt", 64'(bus.gnt_id), 64'd0);
      bus.s_ready = 1'b1;
      step();
      chk("t5_no_ack", 64'({bus.m0_ack, bus.m1_ack}), 64'd0);
      rst = 1'b1; bus.s_ready = 1'b0;
      bus.m0_req = 1'b1; bus.m0_addr = 32'h600;
      step();
      chk("t5_regrant_m0", 64'(bus.gnt_id), 64'd0);
      chk("t5_regrant_addr", 64'(bus.s_addr), 64'h600);
      bus.s_ready = 1'b1;
      step();
      chk("t5_m0_ack", 64'(bus.m0_ack), 64'd1);
      bus.m0_req = 1'b0; bus.m1_req = 1'b0; bus.s_ready = 1'b0;
      step();
      $display("txn reset-abort then m0 grant");

      // 6: m0 holds req through its ack cycle
      bus.m0_req = 1'b1; bus.m0_addr = 32'h700;
      step();
      chk("t6_valid", 64'(bus.s_valid), 64'd1);
      bus.s_ready = 1'b1;
      step();
      chk("t6_ack", 64'(bus.m0_ack), 64'd1);
      chk("t6_resp_valid", 64'(bus.s_valid), 64'd0);
      bus.s_ready = 1'b0;
      step();
      chk("t6_no_regrant", 64'(bus.s_valid), 64'd0);
      chk("t6_ack_once", 64'(bus.m0_ack), 64'd0);
      step();
      chk("t6_regrant", 64'(bus.s_valid), 64'd1);
      chk("t6_regrant_gnt", 64'(bus.gnt_id), 64'd0);
      bus.s_ready = 1'b1;
      step();
      chk("t6_ack2", 64'(bus.m0_ack), 64'd1);
      bus.m0_req = 1'b0; bus.s_ready = 1'b0;
      step();
      chk("t6_idle", 64'(bus.s_valid), 64'd0);
      $display("txn held-req m0 two grants");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
